pico_mem_arbiter: RTL and testbench
===================================

// Module: pico_mem_arbiter
// PURPOSE
//  Two-master round-robin arbiter for the picorv32 native memory bus. Shares one
//  picorv_mem-style slave port between m0 (picorv32 core) and m1 (loader/debug
//  master). Sits between the requesters and the memory inside the SoC wrapper.
//  Adds one arbitration cycle per transaction; the slave protocol is unchanged.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  slave-ready watchdog limit in clk cycles (only with ARB_TIMEOUT_EN)
//  TO_WIDTH        11    timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk          in   1   clock, all state on rising edge
//  resetn       in   1   asynchronous active-low reset
//  m0_valid     in   1   m0 request; held until m0_ready
//  m0_instr     in   1   m0 instruction-fetch flag
//  m0_addr      in   32  m0 byte address
//  m0_wdata     in   32  m0 write data
//  m0_wstrb     in   4   m0 byte strobes; 0 = read
//  m0_ready     out  1   m0 completion pulse
//  m0_rdata     out  32  m0 read data, valid while m0_ready=1
//  m1_*         --   --  identical set for master 1
//  s_valid      out  1   slave request
//  s_instr      out  1   muxed instr flag
//  s_addr       out  32  muxed address
//  s_wdata      out  32  muxed write data
//  s_wstrb      out  4   muxed strobes
//  s_ready      in   1   slave completion
//  s_rdata      in   32  slave read data
//  grant        out  1   owner of current/last transaction (0=m0, 1=m1)
//  err          out  1   one-cycle pulse on watchdog abort
// BEHAVIOUR
//  - Reset, asynchronous: state=IDLE, s_valid=0, grant=0, last=1 (m0 wins first tie),
//    err=0. m*_ready are 0 because state is not BUSY; m*_rdata=0.
//  - FSM IDLE: if any m*_valid, pick a winner, latch it into grant, go BUSY. No request: stay IDLE.
//  - Pick: one requester wins. Both requesting: the master != last wins.
//  - FSM BUSY: s_valid=1 (registered). s_instr/addr/wdata/wstrb come from the granted master,
//    muxed by the grant register.
//  - Completion in BUSY with s_ready=1, same cycle:
//    - m[grant]_ready = 1; m[grant]_rdata = s_rdata.
//    - other master's ready=0, rdata=0.
//    - next state IDLE; last <= grant.
//  - Latency: request seen in cycle N -> s_valid in N+1. The slave's ready passes through
//    combinationally. One IDLE bubble follows each transaction, so max rate is one
//    transfer per 2 cycles plus slave latency.
//  - Granted master drops valid in BUSY (protocol violation): s_valid stays 1 until s_ready,
//    and the response is discarded (m*_ready suppressed).
//  - Non-granted master keeps its valid high while waiting. It is served next.
//  - No starvation: with both masters continuously requesting, grants strictly alternate.
//  - Reset asserted mid-BUSY: abort immediately to reset values. A slave response arriving
//    after reset release while IDLE is ignored.
// CONFIGURATION
//  - ARB_TIMEOUT_EN defined:
//    - 11-bit counter clears on entry to BUSY and counts each BUSY cycle without s_ready.
//    - When the count reaches TIMEOUT_CYCLES-1 with s_ready still 0:
//      m[grant]_ready=1, m[grant]_rdata=32'hDEAD_BEEF, err=1 for that cycle, s_valid
//      drops next cycle, state goes IDLE.
//    - s_ready in the expiry cycle wins: normal completion, no err.
//  - ARB_TIMEOUT_EN undefined: no counter, BUSY waits indefinitely, err tied 0.
// STRUCTURE
//  - pico_arb_defs.vh: state encodings ST_IDLE/ST_BUSY, ARB_ERR_RDATA=32'hDEAD_BEEF,
//    default TIMEOUT_CYCLES.
//  - Sub-module pico_arb_rr_pick: combinational 2-way round-robin picker.
//    Inputs req[1:0], last; outputs any, win.
//  - Top holds the FSM, grant/last registers, muxes and the optional watchdog.
// TESTING
//  1. Reset, then m0 read 0x0000_0010 alone; slave ready after 2 cycles with 0x1234_5678
//     -> s_valid one cycle after m0_valid; m0_ready=1, m0_rdata=0x1234_5678; m1_ready stays 0.
//  2. m0 and m1 raise valid the same cycle after reset -> m0 served first, then m1;
//     grant sequence 0,1.
//  3. Both masters request continuously for 8 transfers -> grants alternate 0,1,0,1...;
//     each m*_ready pulses 4 times.
//  4. m1 write 0x1000_0000, wdata 0x41, wstrb 0xF, while m0 requests -> s_addr/s_wdata/s_wstrb
//     equal m1's values throughout BUSY; m0 is held until m1 completes.
//  5. resetn asserted mid-BUSY -> s_valid and m*_ready drop immediately; after release,
//     a pending m1 request is re-arbitrated from IDLE.
//  6. ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, s_ready held 0 -> after 16 BUSY cycles: m0_ready=1,
//     m0_rdata=0xDEAD_BEEF, err pulses once; the next request is still served normally.

Source files
------------

// File: rtl/pico_mem_arbiter_pkg.sv
// Shared definitions for the picorv32 two-master memory arbiter:
// FSM state encodings, the watchdog abort read pattern and default sizing.
package pico_mem_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

   // Returned to the granted master when the slave never answers.
   localparam logic [31:0] ARB_ERR_RDATA      = 32'hDEAD_BEEF;

   localparam int          ARB_TIMEOUT_CYCLES = 1024;
   localparam int          ARB_TO_WIDTH       = 11;

endpackage

// File: rtl/pico_arb_rr_pick.sv
// Combinational 2-way round-robin picker. With both requesters active the one
// that did not own the previous transaction wins; otherwise the lone requester.
module pico_arb_rr_pick (
   input  logic [1:0] req,
   input  logic       last,
   output logic       any,
   output logic       win
);

   // Tie goes to the master that was not served last.
   always_comb begin
      any = |req;
      win = (req == 2'b11) ? ~last : req[1];
   end

endmodule

// File: rtl/pico_mem_arbiter.sv
// Two-master round-robin arbiter for the picorv32 native memory bus.
// m0 (core) and m1 (loader/debug) share one slave port; each transaction costs
// one arbitration cycle in IDLE before the slave sees s_valid.
// Optional slave-ready watchdog is built when ARB_TIMEOUT_EN is defined.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no slave request; arbitrate pending masters, latch grant
//   ST_BUSY | s_valid high for the granted master until s_ready/abort
module pico_mem_arbiter
   import pico_mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES,
   parameter int TO_WIDTH       = ARB_TO_WIDTH
) (
   input  logic        clk,
   input  logic        resetn,

   input  logic        m0_valid,
   input  logic        m0_instr,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,

   input  logic        m1_valid,
   input  logic        m1_instr,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,

   output logic        s_valid,
   output logic        s_instr,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic        s_ready,
   input  logic [31:0] s_rdata,

   output logic        grant,
   output logic        err
);

   arb_state_t  state_q, state_d;
   logic        grant_q;
   logic        last_q;
   logic        any;
   logic        win;
   logic        busy;
   logic        expire;
   logic        complete;
   logic [31:0] resp_rdata;

   pico_arb_rr_pick u_pick (
      .req  ({m1_valid, m0_valid}),
      .last (last_q),
      .any  (any),
      .win  (win)
   );

   assign busy = (state_q == ST_BUSY);

`ifdef ARB_TIMEOUT_EN
   localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [TO_WIDTH-1:0] to_cnt;

   // Watchdog: restarts on BUSY entry, advances on every unanswered BUSY cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         to_cnt <= '0;
      end else if (!busy && any) begin
         to_cnt <= '0;
      end else if (busy && !s_ready) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   // A ready arriving in the expiry cycle is a normal completion.
   assign expire = busy && !s_ready && (to_cnt == TO_LAST);
`else
   logic [31:0] unused_cfg;

   assign unused_cfg = 32'(TIMEOUT_CYCLES) ^ 32'(TO_WIDTH);
   assign expire     = 1'b0;
`endif

   assign complete   = busy && (s_ready || expire);
   assign resp_rdata = expire ? ARB_ERR_RDATA : s_rdata;

   // State register; reset aborts any transaction in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: arbitrate in IDLE, leave BUSY on completion or abort.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (any)      state_d = ST_BUSY;
         ST_BUSY: if (complete) state_d = ST_IDLE;
         default:               state_d = ST_IDLE;
      endcase
   end

   // Grant latched at arbitration; last owner recorded at completion.
   // last resets to 1 so m0 wins the first tie.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         grant_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         if (!busy && any) begin
            grant_q <= win;
         end
         if (complete) begin
            last_q <= grant_q;
         end
      end
   end

   // Slave request muxed by the grant register; s_valid is the state flop.
   always_comb begin
      s_valid = busy;
      s_instr = grant_q ? m1_instr : m0_instr;
      s_addr  = grant_q ? m1_addr  : m0_addr;
      s_wdata = grant_q ? m1_wdata : m0_wdata;
      s_wstrb = grant_q ? m1_wstrb : m0_wstrb;
   end

   // Response routing; a master that dropped valid mid-transfer gets nothing.
   always_comb begin
      m0_ready = complete && !grant_q && m0_valid;
      m1_ready = complete &&  grant_q && m1_valid;
      m0_rdata = m0_ready ? resp_rdata : 32'h0;
      m1_rdata = m1_ready ? resp_rdata : 32'h0;
      grant    = grant_q;
      err      = expire;
   end

endmodule

// File: tb/tb_pico_mem_arbiter.sv
// Directed bench for pico_mem_arbiter: per-cycle vector table plus sequences
// for continuous alternation and, when ARB_TIMEOUT_EN is defined, the watchdog.
module tb_pico_mem_arbiter;

   localparam logic [31:0] M0_ADDR  = 32'h0000_0010;
   localparam logic [31:0] M0_WDATA = 32'h0000_0000;
   localparam logic [3:0]  M0_WSTRB = 4'h0;
   localparam logic        M0_INSTR = 1'b1;
   localparam logic [31:0] M1_ADDR  = 32'h1000_0000;
   localparam logic [31:0] M1_WDATA = 32'h0000_0041;
   localparam logic [3:0]  M1_WSTRB = 4'hF;
   localparam logic        M1_INSTR = 1'b0;

   logic        clk = 1'b0;
   logic        resetn;
   logic        m0_valid, m0_instr, m0_ready;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic [3:0]  m0_wstrb;
   logic        m1_valid, m1_instr, m1_ready;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic [3:0]  m1_wstrb;
   logic        s_valid, s_instr, s_ready;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wstrb;
   logic        grant, err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pico_mem_arbiter #(.TIMEOUT_CYCLES(16), .TO_WIDTH(11)) dut (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
      .grant(grant), .err(err)
   );

   typedef struct {
      logic        rst_n;
      logic        m0v;
      logic        m1v;
      logic        sr;
      logic [31:0] rd;
      logic        sv;
      logic        gr;
      logic        r0;
      logic        r1;
      logic [31:0] d0;
      logic [31:0] d1;
   } vec_t;

   localparam int NVEC = 31;
   vec_t tbl [NVEC];

   function automatic vec_t mk(logic rst_n, logic m0v, logic m1v, logic sr, logic [31:0] rd,
                               logic sv, logic gr, logic r0, logic r1,
                               logic [31:0] d0, logic [31:0] d1);
      vec_t v;
      v.rst_n = rst_n; v.m0v = m0v; v.m1v = m1v; v.sr = sr; v.rd = rd;
      v.sv = sv; v.gr = gr; v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1;
      return v;
   endfunction

   task automatic chk(string name, logic [71:0] act, logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cnt0, cnt1, exp_g, n_busy, n_err;
      bit seen;

      // rst  m0v m1v sr  rdata          sv gr r0 r1 d0            d1
      tbl[0]  = mk(1, 1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,        32'h0);
      tbl[1]  = mk(1, 1, 0, 0, 32'h0,         1, 0, 0, 0, 32'h0,        32'h0);
      tbl[2]  = mk(1, 1, 0, 1, 32'h1234_5678, 1, 0, 1, 0, 32'h1234_5678, 32'h0);
      tbl[3]  = mk(1, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,        32'h0);
      tbl[4]  = mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,        32'h0);
      tbl[5]  = mk(1, 1, 1, 0, 32'h0,         0, 0, 0, 0, 32'h0,        32'h0);
      tbl[6]  = mk(1, 1, 1, 1, 32'hAAAA_0000, 1, 0, 1, 0, 32'hAAAA_0000, 32'h0);
      tbl[7]  = mk(1, 1, 1, 0, 32'h0,         0, 0, 0, 0, 32'h0,        32'h0);
      tbl[8]  = mk(1, 1, 1, 1, 32'hBBBB_0001, 1, 1, 0, 1, 32'h0,        32'hBBBB_0001);
      tbl[9]  = mk(1, 1, 1, 0, 32'h0,         0, 1, 0, 0, 32'h0,        32'h0);
      tbl[10] = mk(1, 1, 1, 1, 32'h0000_00C2, 1, 0, 1, 0, 32'h0000_00C2, 32'h0);
      tbl[11] = mk(1, 1, 1, 0, 32'h0,         0, 0, 0, 0, 32'h0,        32'h0);
      tbl[12] = mk(1, 1, 1, 1, 32'h0000_00C3, 1, 1, 0, 1, 32'h0,        32'h0000_00C3);
      tbl[13] = mk(1, 0, 1, 0, 32'h0,         0, 1, 0, 0, 32'h0,        32'h0);
      tbl[14] = mk(1, 1, 1, 0, 32'h0,         1, 1, 0, 0, 32'h0,        32'h0);
      tbl[15] = mk(1, 1, 1, 0, 32'h0,         1, 1, 0, 0, 32'h0,        32'h0);
      tbl[16] = mk(1, 1, 1, 1, 32'h0,         1, 1, 0, 1, 32'h0,        32'h0);
      tbl[17] = mk(1, 1, 0, 0, 32'h0,         0, 1, 0, 0, 32'h0,        32'h0);
      tbl[18] = mk(1, 1, 0, 1, 32'h0000_0055, 1, 0, 1, 0, 32'h0000_0055, 32'h0);
      tbl[19] = mk(1, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,        32'h0);
      tbl[20] = mk(1, 1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,        32'h0);
      tbl[21] = mk(1, 0, 0, 0, 32'h0,         1, 0, 0, 0, 32'h0,        32'h0);
      tbl[22] = mk(1, 0, 0, 1, 32'h0000_0077, 1, 0, 0, 0, 32'h0,        32'h0);
      tbl[23] = mk(1, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,        32'h0);
      tbl[24] = mk(1, 0, 0, 1, 32'h0000_0099, 0, 0, 0, 0, 32'h0,        32'h0);
      tbl[25] = mk(1, 1, 1, 0, 32'h0,         0, 0, 0, 0, 32'h0,        32'h0);
      tbl[26] = mk(1, 1, 1, 0, 32'h0,         1, 1, 0, 0, 32'h0,        32'h0);
      tbl[27] = mk(0, 0, 1, 1, 32'h0000_0011, 0, 0, 0, 0, 32'h0,        32'h0);
      tbl[28] = mk(1, 0, 1, 1, 32'h0000_0022, 0, 0, 0, 0, 32'h0,        32'h0);
      tbl[29] = mk(1, 0, 1, 1, 32'h0000_0033, 1, 1, 0, 1, 32'h0,        32'h0000_0033);
      tbl[30] = mk(1, 0, 0, 0, 32'h0,         0, 1, 0, 0, 32'h0,        32'h0);

      m0_instr = M0_INSTR; m0_addr = M0_ADDR; m0_wdata = M0_WDATA; m0_wstrb = M0_WSTRB;
      m1_instr = M1_INSTR; m1_addr = M1_ADDR; m1_wdata = M1_WDATA; m1_wstrb = M1_WSTRB;
      m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; s_rdata = 32'h0;
      resetn = 1'b0;
      #12;
      @(negedge clk);
      chk("reset_s_valid", 72'(s_valid), 72'(1'b0));
      chk("reset_grant",   72'(grant),   72'(1'b0));
      chk("reset_err",     72'(err),     72'(1'b0));
      step();
      resetn = 1'b1;

      // Per-cycle vector table: drive after the edge, check mid-cycle.
      for (int i = 0; i < NVEC; i++) begin
         resetn   = tbl[i].rst_n;
         m0_valid = tbl[i].m0v;
         m1_valid = tbl[i].m1v;
         s_ready  = tbl[i].sr;
         s_rdata  = tbl[i].rd;
         @(negedge clk);
         chk($sformatf("v%0d_s_valid", i),  72'(s_valid),  72'(tbl[i].sv));
         chk($sformatf("v%0d_grant", i),    72'(grant),    72'(tbl[i].gr));
         chk($sformatf("v%0d_m0_ready", i), 72'(m0_ready), 72'(tbl[i].r0));
         chk($sformatf("v%0d_m1_ready", i), 72'(m1_ready), 72'(tbl[i].r1));
         chk($sformatf("v%0d_m0_rdata", i), 72'(m0_rdata), 72'(tbl[i].d0));
         chk($sformatf("v%0d_m1_rdata", i), 72'(m1_rdata), 72'(tbl[i].d1));
         chk($sformatf("v%0d_err", i),      72'(err),      72'(1'b0));
         if (tbl[i].sv)
            chk($sformatf("v%0d_s_bus", i), 72'({s_instr, s_addr, s_wdata, s_wstrb}),
                tbl[i].gr ? 72'({M1_INSTR, M1_ADDR, M1_WDATA, M1_WSTRB})
                          : 72'({M0_INSTR, M0_ADDR, M0_WDATA, M0_WSTRB}));
         step();
      end

      // Both masters request continuously for 8 transfers; m1 owned the last one.
      cnt0 = 0; cnt1 = 0; exp_g = 0;
      m0_valid = 1'b1; m1_valid = 1'b1;
      for (int t = 0; t < 8; t++) begin
         s_ready = 1'b0;
         @(negedge clk);
         cnt0 += int'(m0_ready); cnt1 += int'(m1_ready);
         step();
         for (int w = 0; w < t % 3; w++) begin
            @(negedge clk);
            cnt0 += int'(m0_ready); cnt1 += int'(m1_ready);
            step();
         end
         s_ready = 1'b1;
         s_rdata = 32'h5000_0000 + 32'(t);
         @(negedge clk);
         chk($sformatf("rr%0d_grant", t), 72'(grant), 72'(exp_g));
         chk($sformatf("rr%0d_rdata", t), 72'(exp_g ? m1_rdata : m0_rdata),
             72'(32'h5000_0000 + 32'(t)));
         cnt0 += int'(m0_ready); cnt1 += int'(m1_ready);
         step();
         exp_g = 1 - exp_g;
      end
      s_ready = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0;
      chk("rr_m0_pulses", 72'(cnt0), 72'(4));
      chk("rr_m1_pulses", 72'(cnt1), 72'(4));
      step();

`ifdef ARB_TIMEOUT_EN
      // Slave never answers: abort on the 16th BUSY cycle with the error pattern.
      m0_valid = 1'b1; s_ready = 1'b0;
      step();
      n_busy = 0; n_err = 0; seen = 1'b0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         @(negedge clk);
         n_err += int'(err);
         if (m0_ready) begin
            seen   = 1'b1;
            n_busy = c;
            chk("to_rdata", 72'(m0_rdata), 72'(32'hDEAD_BEEF));
            chk("to_err",   72'(err),      72'(1'b1));
         end
         step();
      end
      chk("to_seen",  72'(seen),   72'(1'b1));
      chk("to_cycle", 72'(n_busy), 72'(16));
      m0_valid = 1'b0;
      @(negedge clk);
      chk("to_s_valid_drop", 72'(s_valid), 72'(1'b0));
      chk("to_err_pulses",   72'(n_err + int'(err)), 72'(1));
      step();

      // Next request served normally.
      m0_valid = 1'b1;
      step();
      s_ready = 1'b1; s_rdata = 32'h0000_600D;
      @(negedge clk);
      chk("to_next_ready", 72'(m0_ready), 72'(1'b1));
      chk("to_next_rdata", 72'(m0_rdata), 72'(32'h0000_600D));
      chk("to_next_err",   72'(err),      72'(1'b0));
      step();
      s_ready = 1'b0; m0_valid = 1'b0;
      step();

      // Ready arriving exactly in the expiry cycle completes normally.
      m0_valid = 1'b1;
      step();
      for (int c = 1; c < 16; c++) step();
      s_ready = 1'b1; s_rdata = 32'h0000_0BAD;
      @(negedge clk);
      chk("to_edge_ready", 72'(m0_ready), 72'(1'b1));
      chk("to_edge_rdata", 72'(m0_rdata), 72'(32'h0000_0BAD));
      chk("to_edge_err",   72'(err),      72'(1'b0));
      step();
      s_ready = 1'b0; m0_valid = 1'b0;
      step();
`else
      // Without the watchdog a silent slave keeps the transfer pending.
      m0_valid = 1'b1; s_ready = 1'b0;
      step();
      n_err = 0; seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         n_err += int'(err);
         if (m0_ready) seen = 1'b1;
         step();
      end
      chk("nto_no_ready",  72'(seen),    72'(1'b0));
      chk("nto_no_err",    72'(n_err),   72'(0));
      chk("nto_s_valid",   72'(s_valid), 72'(1'b1));
      s_ready = 1'b1; s_rdata = 32'h0000_CAFE;
      @(negedge clk);
      chk("nto_late_rdata", 72'(m0_rdata), 72'(32'h0000_CAFE));
      step();
      s_ready = 1'b0; m0_valid = 1'b0;
      step();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
